// File: rtl/ace_ccu_conflict_table.sv
// Line-address conflict table for the CCU snoop path: tracks in-flight snoop indices and stalls same-index or table-full snoops.
// Optional per-entry watchdog is enabled by defining ACE_CCU_CT_TIMEOUT_EN.
module ace_ccu_conflict_table #(
  parameter int unsigned NoRespPorts   = 4,
  parameter int unsigned NoEntries     = 8,
  parameter int unsigned CmAddrWidth   = 8,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 snoop_valid_i,
  input  logic                                 snoop_ready_i,
  input  logic [CmAddrWidth-1:0]               snoop_addr_i,
  output logic                                 stall_o,
  input  logic [NoRespPorts-1:0]               rel_req_i,
  input  logic [NoRespPorts*CmAddrWidth-1:0]   rel_addr_i,
  output logic                                 full_o,
  output logic                                 empty_o,
  output logic [$clog2(NoEntries+1)-1:0]       occupancy_o,
  output logic                                 spurious_o,
  output logic                                 timeout_o
);

  localparam int unsigned OccW = $clog2(NoEntries + 1);

  if (NoEntries < 2 || NoRespPorts < 1 || TimeoutCycles < 2) begin : g_bad_cfg
  end

  logic [NoEntries-1:0]   valid_q, valid_d;
  logic [CmAddrWidth-1:0] idx_q [NoEntries];
  logic [CmAddrWidth-1:0] idx_d [NoEntries];
  logic [OccW-1:0]        occ_q, occ_d;
  logic                   full_q, full_d;
  logic                   empty_q, empty_d;
  logic                   spurious_q, spurious_d;

  logic [NoEntries-1:0]   snoop_match;
  logic [NoEntries-1:0]   rel_hit;
  logic [NoRespPorts-1:0] port_matched;
  logic [NoEntries-1:0]   alloc_oh;
  logic [NoEntries-1:0]   expire;
  logic                   alloc_en;
  logic                   alloc_found;

  // Lookups use registered state only, so a release never unblocks a snoop in the same cycle.
  for (genvar gi = 0; gi < NoEntries; gi++) begin : g_snoop_match
    assign snoop_match[gi] = valid_q[gi] && (idx_q[gi] == snoop_addr_i);
  end

  assign stall_o  = snoop_valid_i & ((|snoop_match) | full_q);
  assign alloc_en = snoop_valid_i & snoop_ready_i & ~stall_o;

  always_comb begin
    rel_hit      = '0;
    port_matched = '0;
    for (int e = 0; e < NoEntries; e++) begin
      for (int p = 0; p < NoRespPorts; p++) begin
        if (rel_req_i[p] && valid_q[e] &&
            (idx_q[e] == rel_addr_i[p*CmAddrWidth +: CmAddrWidth])) begin
          rel_hit[e]      = 1'b1;
          port_matched[p] = 1'b1;
        end
      end
    end
  end

  assign spurious_d = |(rel_req_i & ~port_matched);

  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int e = 0; e < NoEntries; e++) begin
      if (!valid_q[e] && !alloc_found) begin
        alloc_oh[e] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

`ifdef ACE_CCU_CT_TIMEOUT_EN
  localparam int unsigned AgeW = $clog2(TimeoutCycles + 1);

  logic [AgeW-1:0] age_q [NoEntries];
  logic [AgeW-1:0] age_d [NoEntries];
  logic            timeout_q, timeout_d;

  // A release hitting the entry in its last cycle wins over expiry.
  for (genvar gi = 0; gi < NoEntries; gi++) begin : g_expire
    assign expire[gi] = valid_q[gi] && (age_q[gi] == AgeW'(TimeoutCycles - 1)) && !rel_hit[gi];
  end

  always_comb begin
    for (int e = 0; e < NoEntries; e++) begin
      age_d[e] = age_q[e];
      if (alloc_en && alloc_oh[e]) begin
        age_d[e] = '0;
      end else if (!valid_q[e]) begin
        age_d[e] = '0;
      end else if (age_q[e] < AgeW'(TimeoutCycles)) begin
        age_d[e] = age_q[e] + AgeW'(1);
      end
    end
  end

  assign timeout_d = |expire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timeout_q <= 1'b0;
      for (int e = 0; e < NoEntries; e++) age_q[e] <= '0;
    end else begin
      timeout_q <= timeout_d;
      for (int e = 0; e < NoEntries; e++) age_q[e] <= age_d[e];
    end
  end

  assign timeout_o = timeout_q;
`else
  assign expire    = '0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    valid_d = (valid_q & ~rel_hit & ~expire) | (alloc_en ? alloc_oh : '0);
    for (int e = 0; e < NoEntries; e++) begin
      idx_d[e] = (alloc_en && alloc_oh[e]) ? snoop_addr_i : idx_q[e];
    end
    occ_d = '0;
    for (int e = 0; e < NoEntries; e++) begin
      occ_d = occ_d + OccW'(valid_d[e]);
    end
    full_d  = &valid_d;
    empty_d = ~|valid_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q    <= '0;
      occ_q      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      spurious_q <= 1'b0;
      for (int e = 0; e < NoEntries; e++) idx_q[e] <= '0;
    end else begin
      valid_q    <= valid_d;
      occ_q      <= occ_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      spurious_q <= spurious_d;
      for (int e = 0; e < NoEntries; e++) idx_q[e] <= idx_d[e];
    end
  end

  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign occupancy_o = occ_q;
  assign spurious_o  = spurious_q;

endmodule

// File: tb/tb_ace_ccu_conflict_table.sv
// Directed self-checking bench for ace_ccu_conflict_table (default 4 ports, 8 entries, 8-bit index).
module tb_ace_ccu_conflict_table;

  logic        clk = 1'b0;
  logic        rst;
  logic        snoop_valid;
  logic        snoop_ready;
  logic [7:0]  snoop_addr;
  logic        stall;
  logic [3:0]  rel_req;
  logic [31:0] rel_addr;
  logic        full;
  logic        empty;
  logic [3:0]  occupancy;
  logic        spurious;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  ace_ccu_conflict_table #(
    .NoRespPorts(4), .NoEntries(8), .CmAddrWidth(8), .TimeoutCycles(16)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .snoop_valid_i(snoop_valid), .snoop_ready_i(snoop_ready), .snoop_addr_i(snoop_addr),
    .stall_o(stall),
    .rel_req_i(rel_req), .rel_addr_i(rel_addr),
    .full_o(full), .empty_o(empty), .occupancy_o(occupancy),
    .spurious_o(spurious), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rel(input int p, input logic [7:0] a);
    rel_req[p]          = 1'b1;
    rel_addr[p*8 +: 8]  = a;
  endtask

  task automatic clr_rel();
    rel_req  = '0;
    rel_addr = '0;
  endtask

  initial begin
    rst = 1'b1; snoop_valid = 1'b0; snoop_ready = 1'b0; snoop_addr = '0;
    clr_rel();
    repeat (3) tick();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_spur", spurious, 0);
    chk("rst_tmo", timeout, 0);
    rst = 1'b0;
    tick();
    $display("reset idle checked");

    // ready without valid does nothing
    snoop_ready = 1'b1; snoop_addr = 8'h55;
    tick();
    chk("ready_only_occ", occupancy, 0);
    $display("ready-only ignored");

    // accept 0x12, then same index stalls, release on port 2
    snoop_valid = 1'b1; snoop_addr = 8'h12;
    #1 chk("alloc12_stall", stall, 0);
    tick();
    chk("alloc12_occ", occupancy, 1);
    chk("alloc12_empty", empty, 0);
    chk("hit12_stall", stall, 1);
    set_rel(2, 8'h12);
    #1 chk("rel12_sameN_stall", stall, 1);
    tick();
    clr_rel(); snoop_ready = 1'b0;
    #1 chk("rel12_N1_stall", stall, 0);
    chk("rel12_occ", occupancy, 0);
    chk("rel12_empty", empty, 1);
    chk("rel12_spur", spurious, 0);
    $display("0x12 alloc/stall/release done");

    // fill 0x00..0x07
    snoop_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      snoop_addr = 8'(i);
      tick();
    end
    chk("fill_full", full, 1);
    chk("fill_occ", occupancy, 8);
    snoop_addr = 8'h20;
    #1 chk("full_stall", stall, 1);
    set_rel(0, 8'h03);
    #1 chk("full_relN_stall", stall, 1);
    tick();
    clr_rel();
    #1 chk("after_rel3_full", full, 0);
    chk("after_rel3_occ", occupancy, 7);
    chk("after_rel3_stall", stall, 0);
    tick();
    snoop_valid = 1'b0; snoop_ready = 1'b0;
    #1 chk("alloc20_occ", occupancy, 8);
    chk("alloc20_full", full, 1);
    chk("alloc20_entry3", dut.idx_q[3], 8'h20);
    $display("fill and refill of entry 3 done");

    // two ports release the same index
    set_rel(0, 8'h05); set_rel(3, 8'h05);
    tick();
    clr_rel();
    #1 chk("dup_rel_occ", occupancy, 7);
    chk("dup_rel_spur", spurious, 0);
    chk("dup_rel_full", full, 0);
    $display("duplicate release done");

    // allocate 0x30 while releasing 0x00
    snoop_valid = 1'b1; snoop_ready = 1'b1; snoop_addr = 8'h30;
    set_rel(1, 8'h00);
    tick();
    clr_rel();
    #1 chk("alloc_rel_occ", occupancy, 7);
    chk("alloc_rel_spur", spurious, 0);
    $display("simultaneous alloc/release done");

    // release of the index being allocated is spurious
    snoop_addr = 8'h40;
    set_rel(2, 8'h40);
    tick();
    clr_rel(); snoop_ready = 1'b0;
    #1 chk("alloc40_occ", occupancy, 8);
    chk("alloc40_full", full, 1);
    chk("alloc40_spur", spurious, 1);
    chk("hit40_stall", stall, 1);
    tick();
    chk("alloc40_spur_end", spurious, 0);
    $display("same-cycle alloc/release spurious done");

    // asynchronous reset mid-operation
    snoop_valid = 1'b0;
    #1 rst = 1'b1;
    #1 chk("async_rst_occ", occupancy, 0);
    chk("async_rst_empty", empty, 1);
    chk("async_rst_full", full, 0);
    tick();
    rst = 1'b0;
    tick();
    $display("mid-operation reset done");

    // spurious releases on an empty table
    set_rel(1, 8'h7F); set_rel(3, 8'h7E);
    tick();
    clr_rel();
    #1 chk("spur_pulse", spurious, 1);
    chk("spur_occ", occupancy, 0);
    chk("spur_empty", empty, 1);
    tick();
    chk("spur_one_cycle", spurious, 0);
    $display("spurious release done");

`ifdef ACE_CCU_CT_TIMEOUT_EN
    begin
      int cnt;
      snoop_valid = 1'b1; snoop_ready = 1'b1; snoop_addr = 8'h44;
      tick();
      snoop_valid = 1'b0; snoop_ready = 1'b0;
      cnt = 0;
      while (!timeout && cnt < 40) begin
        tick();
        cnt++;
      end
      chk("tmo_latency", cnt, 16);
      chk("tmo_occ", occupancy, 0);
      tick();
      chk("tmo_one_cycle", timeout, 0);
      snoop_valid = 1'b1; snoop_ready = 1'b1;
      #1 chk("tmo_realloc_stall", stall, 0);
      tick();
      snoop_valid = 1'b0; snoop_ready = 1'b0;
      chk("tmo_realloc_occ", occupancy, 1);
      $display("watchdog expiry done");
    end
`else
    chk("no_tmo", timeout, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ace_ccu_conflict_table.md
Name: ace_ccu_conflict_table

Overview:
Parametrised line-address conflict table for the CCU snoop path, the next-generation conflict manager.
- Records the cache-line index of every snoop transaction accepted by the snoop interconnect.
- Stalls any new snoop whose index is already in flight, or arrives while the table is full.
- Frees entries when any of NoRespPorts response-path ports reports completion for that index.
- New over the previous manager: configurable depth and port count, occupancy/full/empty status, spurious-release flagging, and an optional per-entry watchdog.

Parameters:
NoRespPorts, 4, number of release (response-path) ports; must be >=1
NoEntries, 8, number of in-flight snoop index entries; must be >=2
CmAddrWidth, 8, width of the cache-line index compared
TimeoutCycles, 1024, watchdog limit in cycles; only used with ACE_CCU_CT_TIMEOUT_EN; must be >=2

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
snoop_valid_i  in  1  snoop request presented by interconnect
snoop_ready_i  in  1  interconnect accepts the snoop this cycle
snoop_addr_i  in  CmAddrWidth  line index of presented snoop
stall_o  out  1  snoop must not be accepted this cycle
rel_req_i  in  NoRespPorts  per-port release strobe
rel_addr_i  in  NoRespPorts*CmAddrWidth  per-port release index; port p is bits [p*CmAddrWidth +: CmAddrWidth]
full_o  out  1  all entries valid
empty_o  out  1  no entry valid
occupancy_o  out  $clog2(NoEntries+1)  number of valid entries
spurious_o  out  1  one-cycle pulse: a release matched no entry
timeout_o  out  1  one-cycle pulse: an entry was force-freed (watchdog build only, else tied 0)

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- State per entry: valid bit, index register. With the optional feature, each entry also has an age counter of width $clog2(TimeoutCycles+1).
- Reset:
  - All entries invalid, all age counters 0, occupancy_o=0.
  - empty_o=1, full_o=0, spurious_o=0, timeout_o=0.
  - stall_o=0 while snoop_valid_i=0.
  - Reset asserted mid-operation discards all entries immediately. No releases are owed after reset.
- hit = OR over valid entries of (index == snoop_addr_i), evaluated on registered state.
- stall_o is combinational = snoop_valid_i & (hit | full_o). It has zero latency to the interconnect.
- Allocate when snoop_valid_i & snoop_ready_i & ~stall_o:
  - The lowest-numbered invalid entry becomes valid with snoop_addr_i at the next edge.
  - Its age is cleared.
- Release:
  - For each port p with rel_req_i[p]=1, every valid entry whose index == port p's index is invalidated at the next edge.
  - Several ports naming the same entry in one cycle free it once. occupancy_o decreases by the number of distinct entries freed.
  - A strobe whose index matches no valid entry (registered state) is ignored and sets spurious_o=1 on the next cycle. Several spurious strobes in one cycle still give a single pulse.
- Simultaneous events:
  - A release in cycle N clears the stall no earlier than cycle N+1, so a same-index snoop is accepted no earlier than N+1.
  - Allocate and release of different entries in the same cycle both take effect; occupancy_o changes by +1 minus the number freed.
  - A release naming an index being allocated in the same cycle does not match; it is reported spurious.
  - When full_o=1, a release in cycle N allows allocation in cycle N+1, never in N.
- occupancy_o, full_o and empty_o are registered, consistent with the entry valid bits, and update one cycle after the event.
- Snoop handshake: snoop_ready_i without snoop_valid_i is ignored. An allocation never overwrites a valid entry.

Optional Feature:
Macro: ACE_CCU_CT_TIMEOUT_EN.
- Defined:
  - Each valid entry's age increments every cycle, saturating at TimeoutCycles.
  - When age reaches TimeoutCycles-1 and no release hits the entry that cycle, the entry is invalidated at the next edge.
  - timeout_o pulses for one cycle; several entries expiring together give one pulse.
  - A release in the same cycle as expiry takes priority; no timeout_o.
- Not defined: no age counters exist, entries persist until released, timeout_o is tied 0.

Test Plan:
- Reset then idle -> empty_o=1, full_o=0, occupancy_o=0, stall_o=0, spurious_o=0, timeout_o=0.
- Accept snoop index 0x12; next cycle present 0x12 -> stall_o=1. Release 0x12 on port 2 in cycle N -> stall_o=0 in N+1, occupancy_o back to 0.
- With NoEntries=8, accept indices 0x00..0x07 -> full_o=1, occupancy_o=8, and index 0x20 stalls. Release 0x03 -> 0x20 is accepted the following cycle and lands in entry 3.
- Ports 0 and 3 both release 0x05 in the same cycle -> occupancy_o drops by exactly 1, spurious_o=0.
- Release 0x7F with the table empty -> spurious_o=1 for exactly one cycle, state unchanged.
- Timeout build with TimeoutCycles=16: accept 0x44 and never release -> timeout_o pulses 16 cycles after acceptance, the entry is freed, and 0x44 is accepted again.
